// File: rtl/serial_paralelo_pkg.sv
// serial_paralelo_pkg: shared FSM state type and default alignment comma for the deserializer
package serial_paralelo_pkg;
  typedef enum logic [1:0] {SEARCH, ALIGN, ACTIVE} state_t;
  localparam logic [15:0] COMMA_DEFAULT = 16'h00BC;
endpackage

// File: rtl/serial_paralelo_sync.sv
// serial_paralelo_sync: comma-aligned serial-to-parallel deserializer (ports: clk8f, reset, serial_in -> data_out, valid_out, word_stb, locked)
module serial_paralelo_sync
  import serial_paralelo_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter logic [DATA_W-1:0] COMMA = COMMA_DEFAULT[DATA_W-1:0],
  parameter int LOCK_COUNT = 4
) (
  input  logic              clk8f,
  input  logic              reset,
  input  logic              serial_in,
  output logic [DATA_W-1:0] data_out,
  output logic              valid_out,
  output logic              word_stb,
  output logic              locked
);
  localparam int BW = $clog2(DATA_W);
  localparam logic [BW-1:0] LAST = BW'(DATA_W - 1);
  localparam logic [3:0] LC = 4'(LOCK_COUNT);
  state_t r_state, w_state;
  logic [DATA_W-2:0] r_sr;
  logic [BW-1:0] r_bit_cnt, w_bit_cnt;
  logic [3:0] r_comma_cnt, w_comma_cnt;
  logic [DATA_W-1:0] r_data, w_data;
  logic r_valid, w_valid, r_stb, w_stb;
  logic [DATA_W-1:0] w_word;
  logic w_match, w_bound;
  logic [3:0] w_cc_inc;
  logic [BW-1:0] w_bit_wrap;
  assign w_word = {r_sr, serial_in};
  assign w_match = w_word == COMMA;
  assign w_bound = r_bit_cnt == LAST;
  assign w_cc_inc = r_comma_cnt + 4'd1;
  assign w_bit_wrap = w_bound ? '0 : r_bit_cnt + 1'b1;
  always_comb begin
    w_state = r_state;
    w_bit_cnt = r_bit_cnt;
    w_comma_cnt = r_comma_cnt;
    w_data = r_data;
    w_valid = r_valid;
    w_stb = 1'b0;
    unique case (r_state)
      SEARCH: if (w_match) begin
        w_comma_cnt = 4'd1;
        w_bit_cnt = '0;
        w_state = (LC == 4'd1) ? ACTIVE : ALIGN;
      end
      ALIGN: begin
        w_bit_cnt = w_bit_wrap;
        if (w_bound && w_match) begin
          w_comma_cnt = w_cc_inc;
          w_state = (w_cc_inc == LC) ? ACTIVE : ALIGN;
        end else if (w_bound) begin
          w_comma_cnt = '0;
          w_state = SEARCH;
        end
      end
      ACTIVE: begin
        w_bit_cnt = w_bit_wrap;
        if (w_bound) begin
          w_stb = 1'b1;
          w_valid = !w_match;
          w_data = w_match ? r_data : w_word;
        end
      end
      default: w_state = SEARCH;
    endcase
  end
  always_ff @(posedge clk8f) begin
    if (reset) begin
      r_state <= SEARCH;
      r_sr <= '0;
      r_bit_cnt <= '0;
      r_comma_cnt <= '0;
      r_data <= '0;
      r_valid <= 1'b0;
      r_stb <= 1'b0;
    end else begin
      r_state <= w_state;
      r_sr <= w_word[DATA_W-2:0];
      r_bit_cnt <= w_bit_cnt;
      r_comma_cnt <= w_comma_cnt;
      r_data <= w_data;
      r_valid <= w_valid;
      r_stb <= w_stb;
    end
  end
  assign data_out = r_data;
  assign valid_out = r_valid;
  assign word_stb = r_stb;
  assign locked = r_state == ACTIVE;
endmodule

// File: tb/tb_serial_paralelo_sync.sv
// tb_serial_paralelo_sync: directed table-driven bench for the comma-aligned deserializer
module tb_serial_paralelo_sync;
  logic clk8f = 1'b0;
  logic reset = 1'b1;
  logic serial_in = 1'b0;
  logic [7:0] data_out;
  logic valid_out, word_stb, locked;
  int checks = 0;
  int errors = 0;
  typedef struct {
    logic [7:0] w;
    logic lk;
    logic vl;
    logic sb;
    logic [7:0] d;
  } vec_t;
  vec_t tbl[8];
  serial_paralelo_sync #(.DATA_W(8), .COMMA(8'hBC), .LOCK_COUNT(4)) dut (
    .clk8f(clk8f), .reset(reset), .serial_in(serial_in),
    .data_out(data_out), .valid_out(valid_out), .word_stb(word_stb), .locked(locked)
  );
  always #5 clk8f = ~clk8f;
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic send_bit(input logic b, input logic r);
    @(negedge clk8f);
    serial_in = b;
    reset = r;
    @(posedge clk8f);
    #1;
  endtask
  task automatic send_word(input logic [7:0] w);
    for (int i = 7; i >= 0; i--) send_bit(w[i], 1'b0);
  endtask
  task automatic chk_all(input string name, input logic lk, input logic vl, input logic sb, input logic [7:0] d);
    chk({name, " locked"}, int'(locked), int'(lk));
    chk({name, " valid"}, int'(valid_out), int'(vl));
    chk({name, " stb"}, int'(word_stb), int'(sb));
    chk({name, " data"}, int'(data_out), int'(d));
  endtask
  task automatic do_reset();
    for (int i = 0; i < 3; i++) send_bit(i[0], 1'b1);
  endtask
  initial begin
    logic prev_lk;
    tbl[0] = '{8'hBC, 1'b0, 1'b0, 1'b0, 8'h00};
    tbl[1] = '{8'hBC, 1'b0, 1'b0, 1'b0, 8'h00};
    tbl[2] = '{8'hBC, 1'b0, 1'b0, 1'b0, 8'h00};
    tbl[3] = '{8'hBC, 1'b1, 1'b0, 1'b0, 8'h00};
    tbl[4] = '{8'h5A, 1'b1, 1'b1, 1'b1, 8'h5A};
    tbl[5] = '{8'hBC, 1'b1, 1'b0, 1'b1, 8'h5A};
    tbl[6] = '{8'hC3, 1'b1, 1'b1, 1'b1, 8'hC3};
    tbl[7] = '{8'h00, 1'b1, 1'b1, 1'b1, 8'h00};
    do_reset();
    chk_all("reset", 1'b0, 1'b0, 1'b0, 8'h00);
    prev_lk = 1'b0;
    for (int v = 0; v < 8; v++) begin
      for (int i = 7; i >= 1; i--) begin
        send_bit(tbl[v].w[i], 1'b0);
        chk($sformatf("vec%0d mid stb", v), int'(word_stb), 0);
        chk($sformatf("vec%0d mid locked", v), int'(locked), int'(prev_lk));
      end
      send_bit(tbl[v].w[0], 1'b0);
      chk_all($sformatf("vec%0d", v), tbl[v].lk, tbl[v].vl, tbl[v].sb, tbl[v].d);
      prev_lk = tbl[v].lk;
    end
    do_reset();
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    for (int k = 0; k < 3; k++) send_word(8'hBC);
    chk("offset pre-lock", int'(locked), 0);
    send_word(8'hBC);
    chk("offset lock", int'(locked), 1);
    send_word(8'h5A);
    chk_all("offset 5A", 1'b1, 1'b1, 1'b1, 8'h5A);
    send_bit(1'b1, 1'b0);
    chk("offset stb drop", int'(word_stb), 0);
    chk("offset valid held", int'(valid_out), 1);
    do_reset();
    send_word(8'hBC);
    send_word(8'hBC);
    send_word(8'h00);
    chk("false align locked", int'(locked), 0);
    for (int k = 0; k < 3; k++) send_word(8'hBC);
    chk("relock pre", int'(locked), 0);
    send_word(8'hBC);
    chk("relock", int'(locked), 1);
    send_word(8'h5A);
    chk_all("relock 5A", 1'b1, 1'b1, 1'b1, 8'h5A);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b1);
    chk_all("midword reset", 1'b0, 1'b0, 1'b0, 8'h00);
    for (int k = 0; k < 3; k++) send_word(8'hBC);
    chk("post reset pre-lock", int'(locked), 0);
    send_word(8'hBC);
    chk("post reset lock", int'(locked), 1);
    send_word(8'h3C);
    chk_all("post reset 3C", 1'b1, 1'b1, 1'b1, 8'h3C);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
